// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the coherent data cache
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Wide enough for the tag of any legal SETS (>= 2); unused upper bits stay 0.
  localparam int TAGW = 28;

  typedef enum logic [1:0] {CI, CS, CM} msi_t;

  typedef struct packed {
    msi_t            st;
    logic [TAGW-1:0] tag;
    word_t [1:0]     data;
  } dcache_frame_t;

  typedef struct packed {
    logic [28:0] blkaddr;
    logic        blk;
    logic [1:0]  bytoff;
  } dcachef_t;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, SNP, SUP0, SUP1,
    FSCAN, FWB0, FWB1, HALTED
  } dc_state_t;

endpackage

// File: rtl/coherent_dcache.sv
// rtl/coherent_dcache.sv - direct-mapped write-back MSI data cache, 2-word blocks
module coherent_dcache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);

  localparam int IW = $clog2(SETS);
  localparam logic [IW-1:0] LAST = IW'(SETS - 1);

  function automatic logic [IW-1:0] idx_of(input dcachef_t a);
    return a.blkaddr[IW-1:0];
  endfunction

  function automatic logic [TAGW-1:0] tag_of(input dcachef_t a);
    return TAGW'(a.blkaddr >> IW);
  endfunction

  function automatic word_t baddr(input logic [TAGW-1:0] tag, input logic [IW-1:0] idx,
                                  input logic blk);
    logic [28:0] b;
    b = 29'({tag, idx});
    return {b, blk, 2'b00};
  endfunction

  dc_state_t     state_q, state_d;
  dc_state_t     ret_q, ret_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          flushed_q, flushed_d;
  logic          inv_q, inv_d;
  word_t         snp_q, snp_d;
  dcache_frame_t frames_q [SETS];
  dcache_frame_t frames_d [SETS];

  dcachef_t      req_a, snp_now, sup_a;
  logic [IW-1:0] ri, si, pi;
  dcache_frame_t cur_f, snp_f, sup_f, fl_f;
  logic          tag_hit, ld_hit, st_hit, snp_match, snp_dirty;
  logic          unused_bits;

  assign req_a   = dcachef_t'(dmemaddr);
  assign snp_now = dcachef_t'(ccsnoopaddr);
  assign sup_a   = dcachef_t'(snp_q);
  assign ri      = idx_of(req_a);
  assign si      = idx_of(snp_now);
  assign pi      = idx_of(sup_a);
  assign cur_f   = frames_q[ri];
  assign snp_f   = frames_q[si];
  assign sup_f   = frames_q[pi];
  assign fl_f    = frames_q[idx_q];

  assign tag_hit   = (cur_f.st != CI) && (cur_f.tag == tag_of(req_a));
  assign ld_hit    = dmemREN && tag_hit;
  assign st_hit    = dmemWEN && tag_hit && (cur_f.st == CM);
  assign snp_match = (snp_f.st != CI) && (snp_f.tag == tag_of(snp_now));
  assign snp_dirty = snp_match && (snp_f.st == CM);
  assign flushed   = flushed_q;

  assign unused_bits = ^{req_a.bytoff, snp_now.blk, snp_now.bytoff, sup_a.blk, sup_a.bytoff};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      idx_q     <= '0;
      flushed_q <= 1'b0;
      inv_q     <= 1'b0;
      snp_q     <= '0;
      for (int i = 0; i < SETS; i++) frames_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      idx_q     <= idx_d;
      flushed_q <= flushed_d;
      inv_q     <= inv_d;
      snp_q     <= snp_d;
      frames_q  <= frames_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    idx_d     = idx_q;
    flushed_d = flushed_q;
    inv_d     = inv_q;
    snp_d     = snp_q;
    frames_d  = frames_q;
    case (state_q)
      IDLE: begin
        if (ccwait) begin
          state_d = SNP;
          ret_d   = IDLE;
          inv_d   = 1'b0;
        end else if (halt) begin
          state_d = FSCAN;
          idx_d   = '0;
        end else if (st_hit) begin
          frames_d[ri].data[req_a.blk] = dmemstore;
        end else if ((dmemREN && !ld_hit) || dmemWEN) begin
          // A dirty victim can only belong to another block, so it must go out first.
          state_d = (cur_f.st == CM) ? WB0 : LD0;
        end
      end
      WB0: if (!dwait) state_d = WB1;
      WB1: if (!dwait) state_d = LD0;
      LD0: begin
        if (!dwait) begin
          frames_d[ri].data[0] = dload;
          state_d = LD1;
        end
      end
      LD1: begin
        if (!dwait) begin
          frames_d[ri].data[1] = dload;
          frames_d[ri].tag     = tag_of(req_a);
          frames_d[ri].st      = dmemWEN ? CM : CS;
          state_d = IDLE;
        end
      end
      SNP: begin
        inv_d = inv_q | ccinv;
        snp_d = ccsnoopaddr;
        if (!ccwait) begin
          state_d = ret_q;
        end else if (snp_dirty) begin
          state_d = SUP0;
        end else if (snp_match && ccinv) begin
          frames_d[si].st = CI;
        end
      end
      SUP0: begin
        inv_d = inv_q | ccinv;
        if (!dwait) state_d = SUP1;
      end
      SUP1: begin
        inv_d = inv_q | ccinv;
        if (!dwait) begin
          frames_d[pi].st = (inv_q || ccinv) ? CI : CS;
          state_d = ret_q;
        end
      end
      FSCAN: begin
        if (ccwait) begin
          state_d = SNP;
          ret_d   = FSCAN;
          inv_d   = 1'b0;
        end else if (fl_f.st == CM) begin
          state_d = FWB0;
        end else if (idx_q == LAST) begin
          state_d   = HALTED;
          flushed_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FWB0: if (!dwait) state_d = FWB1;
      FWB1: begin
        if (!dwait) begin
          frames_d[idx_q].st = CI;
          if (idx_q == LAST) begin
            state_d   = HALTED;
            flushed_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FSCAN;
          end
        end
      end
      HALTED: begin
        // Only clean lines remain, so snoops here never need a supply.
        if (ccwait) begin
          state_d = SNP;
          ret_d   = HALTED;
          inv_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ccwait && !halt) begin
          dhit     = ld_hit || st_hit;
          dmemload = ld_hit ? cur_f.data[req_a.blk] : '0;
        end
      end
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = baddr(cur_f.tag, ri, state_q == WB1);
        dstore = cur_f.data[state_q == WB1];
      end
      LD0, LD1: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = dmemWEN;
        daddr   = baddr(tag_of(req_a), ri, state_q == LD1);
      end
      SNP: ccwrite = snp_dirty;
      SUP0, SUP1: begin
        dWEN   = 1'b1;
        daddr  = {sup_a.blkaddr, state_q == SUP1, 2'b00};
        dstore = sup_f.data[state_q == SUP1];
      end
      FWB0, FWB1: begin
        dWEN   = 1'b1;
        daddr  = baddr(fl_f.tag, idx_q, state_q == FWB1);
        dstore = fl_f.data[state_q == FWB1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherent_dcache.sv
// tb/tb_coherent_dcache.sv - directed and randomized checks of coherent_dcache
module tb_coherent_dcache;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic        dhit, flushed, dREN, dWEN, cctrans, ccwrite;
  logic [31:0] dmemload, daddr, dstore;
  logic        dwait = 1'b0;
  logic [31:0] dload = '0;
  logic        ccwait = 1'b0, ccinv = 1'b0;
  logic [31:0] ccsnoopaddr = '0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        cct;
    logic        ccw;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] mem [256];
  bit          mem_ready = 1'b0;
  bit          stall_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  coherent_dcache #(.SETS(8)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .cctrans(cctrans), .ccwrite(ccwrite),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  always #5 CLK = ~CLK;

  // Bus memory: answers at the falling edge and logs every accepted word.
  always @(negedge CLK) begin
    beat_t b;
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[8'h10] = 32'hAAAA0000;
      mem[8'h11] = 32'hAAAA0001;
      mem[8'h20] = 32'hBBBB0000;
      mem[8'h21] = 32'hBBBB0001;
      mem_ready = 1'b1;
    end
    dload = mem[daddr[9:2]];
    dwait = (dREN || dWEN) && stall_en && ($urandom_range(0, 2) == 0);
    if ((dREN || dWEN) && !dwait && nRST) begin
      b.wr = dWEN;
      b.addr = daddr;
      b.data = dWEN ? dstore : dload;
      b.cct = cctrans;
      b.ccw = ccwrite;
      beats.push_back(b);
      if (dWEN) mem[daddr[9:2]] = dstore;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; ccwait = 1'b0; ccinv = 1'b0;
    cycles(2);
    nRST = 1'b1;
    cycles(1);
  endtask

  task automatic cpu_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int cyc);
    bit done = 1'b0;
    dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = d;
    cyc = 0; rd = '0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge CLK);
      if (dhit) begin
        rd = dmemload;
        done = 1'b1;
      end else begin
        cyc++;
      end
    end
    chk("op_completes", 32'(done), 32'd1);
    @(posedge CLK);
    #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int i, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, input bit ccw);
    if (i >= beats.size()) begin
      chk({tag, "_present"}, 32'(beats.size()), 32'(i + 1));
    end else begin
      chk({tag, "_wr"}, 32'(beats[i].wr), 32'(wr));
      chk({tag, "_addr"}, beats[i].addr, a);
      chk({tag, "_data"}, beats[i].data, d);
      if (!wr) begin
        chk({tag, "_cctrans"}, 32'(beats[i].cct), 32'd1);
        chk({tag, "_ccwrite"}, 32'(beats[i].ccw), 32'(ccw));
      end
    end
  endtask

  logic [31:0] rd, a, d, v54, va8;
  int          cyc, base, n, w, idx, tg, nexp;
  bit          wr, hit, evict, inv, found;
  bit          rv [8];
  bit          rm [8];
  int          rt [8];
  logic [31:0] gmem [64];

  initial begin
    do_reset();

    // reset state
    chk("rst_dhit", 32'(dhit), 0);
    chk("rst_dmemload", dmemload, 0);
    chk("rst_flushed", 32'(flushed), 0);
    chk("rst_dREN", 32'(dREN), 0);
    chk("rst_dWEN", 32'(dWEN), 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_dstore", dstore, 0);
    chk("rst_cctrans", 32'(cctrans), 0);
    chk("rst_ccwrite", 32'(ccwrite), 0);

    // 1: read miss fills S
    base = beats.size();
    cpu_op(0, 32'h40, 0, rd, cyc);
    chk("t1_lat", 32'(cyc), 3);
    chk("t1_load", rd, 32'hAAAA0000);
    chk("t1_nbeats", 32'(beats.size() - base), 2);
    chk_beat("t1_b0", base, 0, 32'h40, 32'hAAAA0000, 0);
    chk_beat("t1_b1", base + 1, 0, 32'h44, 32'hAAAA0001, 0);
    base = beats.size();
    cpu_op(0, 32'h44, 0, rd, cyc);
    chk("t1_hit_lat", 32'(cyc), 0);
    chk("t1_hit_load", rd, 32'hAAAA0001);
    chk("t1_hit_nbeats", 32'(beats.size() - base), 0);

    // 2: store to S line upgrades with ccwrite
    base = beats.size();
    cpu_op(1, 32'h44, 32'h1234, rd, cyc);
    chk("t2_lat", 32'(cyc), 3);
    chk("t2_nbeats", 32'(beats.size() - base), 2);
    chk_beat("t2_b0", base, 0, 32'h40, 32'hAAAA0000, 1);
    chk_beat("t2_b1", base + 1, 0, 32'h44, 32'hAAAA0001, 1);
    cpu_op(0, 32'h44, 0, rd, cyc);
    chk("t2_load_lat", 32'(cyc), 0);
    chk("t2_load", rd, 32'h1234);

    // 3: invalidating snoop of an M line supplies both words
    base = beats.size();
    ccwait = 1'b1; ccsnoopaddr = 32'h40; ccinv = 1'b1;
    dmemREN = 1'b1; dmemaddr = 32'h40;
    @(negedge CLK);
    chk("t3_dhit_blocked", 32'(dhit), 0);
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    @(negedge CLK);
    chk("t3_ccwrite", 32'(ccwrite), 1);
    for (n = 0; n < 50 && beats.size() < base + 2; n++) cycles(1);
    ccwait = 1'b0; ccinv = 1'b0;
    cycles(2);
    chk("t3_nbeats", 32'(beats.size() - base), 2);
    chk_beat("t3_b0", base, 1, 32'h40, 32'hAAAA0000, 0);
    chk_beat("t3_b1", base + 1, 1, 32'h44, 32'h1234, 0);
    cpu_op(0, 32'h40, 0, rd, cyc);
    chk("t3_reload_lat", 32'(cyc), 3);
    chk("t3_reload", rd, 32'hAAAA0000);

    // 4: dirty conflict writes back before the fill
    cpu_op(1, 32'h40, 32'h5555, rd, cyc);
    base = beats.size();
    cpu_op(0, 32'h80, 0, rd, cyc);
    chk("t4_lat", 32'(cyc), 5);
    chk("t4_load", rd, 32'hBBBB0000);
    chk("t4_nbeats", 32'(beats.size() - base), 4);
    chk_beat("t4_b0", base, 1, 32'h40, 32'h5555, 0);
    chk_beat("t4_b1", base + 1, 1, 32'h44, 32'h1234, 0);
    chk_beat("t4_b2", base + 2, 0, 32'h80, 32'hBBBB0000, 0);
    chk_beat("t4_b3", base + 3, 0, 32'h84, 32'hBBBB0001, 0);

    // 5: flush of M lines at idx 2 and 5
    v54 = mem[8'h15];
    va8 = mem[8'h2A];
    cpu_op(1, 32'h50, 32'hCAFE0050, rd, cyc);
    cpu_op(1, 32'hAC, 32'hCAFE00AC, rd, cyc);
    base = beats.size();
    halt = 1'b1;
    for (n = 0; n < 100 && !flushed; n++) @(negedge CLK);
    chk("t5_flushed", 32'(flushed), 1);
    cycles(1);
    chk("t5_nbeats", 32'(beats.size() - base), 4);
    chk_beat("t5_b0", base, 1, 32'h50, 32'hCAFE0050, 0);
    chk_beat("t5_b1", base + 1, 1, 32'h54, v54, 0);
    chk_beat("t5_b2", base + 2, 1, 32'hA8, va8, 0);
    chk_beat("t5_b3", base + 3, 1, 32'hAC, 32'hCAFE00AC, 0);
    dmemREN = 1'b1; dmemaddr = 32'h80;
    repeat (3) begin
      @(negedge CLK);
      chk("t5_halted_nohit", 32'(dhit), 0);
    end
    chk("t5_flushed_sticky", 32'(flushed), 1);
    chk("t5_no_more_beats", 32'(beats.size() - base), 4);
    dmemREN = 1'b0;

    // 6: reset during LD1
    do_reset();
    dmemREN = 1'b1; dmemaddr = 32'h40;
    found = 1'b0;
    for (n = 0; n < 20 && !found; n++) begin
      @(negedge CLK);
      found = dREN && (daddr == 32'h44);
    end
    chk("t6_reached_ld1", 32'(found), 1);
    nRST = 1'b0;
    #1;
    chk("t6_dREN_drop", 32'(dREN), 0);
    chk("t6_cctrans_drop", 32'(cctrans), 0);
    chk("t6_dWEN_low", 32'(dWEN), 0);
    dmemREN = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cycles(1);
    cpu_op(0, 32'h40, 0, rd, cyc);
    chk("t6_miss_after_rst", 32'(cyc), 3);
    cpu_op(0, 32'h0, 0, rd, cyc);
    chk("t6_tag0_misses", 32'(cyc), 3);

    // randomized loads/stores/snoops against a flat-memory model
    do_reset();
    stall_en = 1'b1;
    for (int i = 0; i < 64; i++) gmem[i] = mem[i];
    for (int i = 0; i < 8; i++) begin
      rv[i] = 1'b0; rm[i] = 1'b0; rt[i] = 0;
    end
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        w = $urandom_range(0, 63);
        inv = $urandom_range(0, 1) == 1;
        idx = (w >> 1) & 7;
        tg = w >> 4;
        hit = rv[idx] && rt[idx] == tg;
        nexp = (hit && rm[idx]) ? 2 : 0;
        base = beats.size();
        ccwait = 1'b1; ccsnoopaddr = 32'(w * 4); ccinv = inv;
        for (n = 0; n < 60 && beats.size() < base + nexp; n++) cycles(1);
        cycles(3);
        ccwait = 1'b0; ccinv = 1'b0;
        cycles(2);
        chk("rnd_snp_nbeats", 32'(beats.size() - base), 32'(nexp));
        for (int k = 0; k < nexp; k++)
          chk_beat("rnd_snp", base + k, 1, 32'(((w & ~1) + k) * 4), gmem[(w & ~1) + k], 0);
        if (hit) begin
          if (rm[idx]) begin
            rm[idx] = 1'b0;
            rv[idx] = !inv;
          end else if (inv) begin
            rv[idx] = 1'b0;
          end
        end
      end
      w = $urandom_range(0, 63);
      wr = $urandom_range(0, 1) == 1;
      d = $urandom;
      idx = (w >> 1) & 7;
      tg = w >> 4;
      hit = rv[idx] && rt[idx] == tg && (!wr || rm[idx]);
      evict = rv[idx] && rm[idx] && rt[idx] != tg;
      nexp = hit ? 0 : (evict ? 4 : 2);
      base = beats.size();
      cpu_op(wr, 32'(w * 4), d, rd, cyc);
      if (hit) chk("rnd_hit_lat", 32'(cyc), 0);
      else chk("rnd_miss_lat_min3", 32'(cyc >= 3), 1);
      chk("rnd_nbeats", 32'(beats.size() - base), 32'(nexp));
      if (evict) begin
        for (int k = 0; k < 2; k++) begin
          a = 32'(((rt[idx] * 8 + idx) * 2 + k) * 4);
          chk_beat("rnd_wb", base + k, 1, a, gmem[a[7:2]], 0);
        end
      end
      if (!hit) begin
        for (int k = 0; k < 2; k++)
          chk_beat("rnd_ld", base + nexp - 2 + k, 0, 32'(((w & ~1) + k) * 4),
                   gmem[(w & ~1) + k], wr);
      end
      if (!wr) chk("rnd_load", rd, gmem[w]);
      if (!hit) begin
        rv[idx] = 1'b1;
        rt[idx] = tg;
        rm[idx] = wr;
      end
      if (wr) gmem[w] = d;
    end

    halt = 1'b1;
    for (n = 0; n < 400 && !flushed; n++) @(negedge CLK);
    chk("rnd_flushed", 32'(flushed), 1);
    cycles(1);
    for (int i = 0; i < 64; i++) chk("rnd_mem_after_flush", mem[i], gmem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
